regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
- Register file and write-back stage of the single-cycle processor.
- Sources the ALU A/B operands through two combinational read ports.
- Consumes the ALU result R through one synchronous write port.
- Latches the ALU flags (cout, ovf, ze) into a flag register for later branch/compare use.
- Sits directly around the ALU: upstream as the operand source, downstream as the result sink.

Parameters:
DATA_W, 32, register and ALU data width
ADDR_W, 5, register address width; depth = 2**ADDR_W (32 registers)
BYPASS, 0, 1 = write-through forwarding of same-cycle write data onto the read ports; 0 = reads return pre-edge contents

Ports:
clk  in  1  system clock, rising edge active
rst  in  1  reset, asynchronous, active-high
rs_addr  in  ADDR_W  read port A address (drives ALU A)
rt_addr  in  ADDR_W  read port B address (drives ALU B)
rs_data  out  DATA_W  read port A data
rt_data  out  DATA_W  read port B data
wr_en  in  1  write enable for the register file
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data (ALU R)
flag_we  in  1  flag register load enable
cout_in  in  1  ALU carry out
ovf_in  in  1  ALU overflow
ze_in  in  1  ALU zero
cout_q  out  1  registered carry
ovf_q  out  1  registered overflow
ze_q  out  1  registered zero

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset (rst=1, any time):
  - All registers clear to 0 immediately, without waiting for a clock edge.
  - cout_q, ovf_q and ze_q clear to 0 immediately.
  - rs_data and rt_data read 0.
  - rst dominates: a wr_en or flag_we asserted in a cycle where rst is high at the edge has no effect.
- Deassertion: the first write takes effect on the first rising clk edge with rst=0.
- Register 0:
  - Hardwired to 0; writes with wr_addr=0 are discarded.
  - Reads of address 0 return 0 always, including when a same-cycle write targets address 0 with BYPASS=1.
- Write:
  - On a rising clk edge with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data.
  - Latency is 1 edge.
  - wr_en=0 leaves all registers unchanged.
- Read:
  - Purely combinational: rs_data = regs[rs_addr], rt_data = regs[rt_addr]. Latency is 0 cycles.
  - Both ports may address the same register and must both return its value.
- Read-during-write (same address, wr_en=1, address!=0):
  - BYPASS=0: the read port shows the old value until the edge, then the new value.
  - BYPASS=1: the read port shows wr_data in the same cycle.
  - Each port is evaluated independently.
- Flags:
  - On a rising clk edge with flag_we=1: {cout_q, ovf_q, ze_q} <= {cout_in, ovf_in, ze_in}.
  - flag_we=0 holds the previous values.
  - The flag update is independent of wr_en; both may occur in the same cycle.
- No width conversion: wr_data is stored bit-exact. Unknown or X addresses are not required to be handled.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W and ADDR_W defaults;
  - REG_ZERO = 0 (address constant);
  - the flag bundle ordering constant {cout, ovf, ze}, shared with the ALU and branch logic.
- One sub-module, flag_reg:
  - 3-bit enable-loaded register with asynchronous active-high clear;
  - instantiated once inside regfile_wb.
- The register array and read muxing stay inline.

Test Plan:
- Reset mid-operation: write 32'hDEADBEEF to r5, then pulse rst between edges → rs_data(rs_addr=5) = 0 before the next edge; flags = 0.
- Write/read: wr_en=1, wr_addr=3, wr_data=32'h139876AD, edge → rs_data(3) = 32'h139876AD and rt_data(3) = 32'h139876AD.
- r0 immunity: wr_en=1, wr_addr=0, wr_data=32'hFFFFFFFF, edge → rs_data(0) = 0. With BYPASS=1 in the same cycle, rs_data(0) = 0.
- Read-during-write: r7 = 32'h00000018; in the next cycle write 32'h00005210 to r7.
  - BYPASS=0: rs_data(7) = 32'h00000018 before the edge, 32'h00005210 after.
  - BYPASS=1: rs_data(7) = 32'h00005210 immediately.
- Flags:
  - Feed ALU add of 32'h80000000 + 32'h80000000 (cout=1, ovf=1, ze=1) with flag_we=1, edge → flags = 1/1/1.
  - Next cycle: flag_we=0, inputs 0/0/0, edge → flags remain 1/1/1.
- Simultaneous write and flag load: wr_en=1 to r31 with 32'h00000002, flag_we=1 with ze_in=0, same edge → r31 = 2 and ze_q = 0, both updated on that edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register file / write-back stage.
// Flag bundle order {cout, ovf, ze} is common to ALU and branch logic.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  localparam int FLAG_W     = 3;
  localparam int FLAG_COUT  = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZE    = 0;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic ze;
  } flags_t;

endpackage

// File: rtl/regfile_flag_reg.sv
// Enable-loaded ALU flag register with async active-high clear.
// Bit order follows the shared {cout, ovf, ze} bundle.
module flag_reg
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [FLAG_W-1:0] d,
  output logic [FLAG_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/regfile_wb.sv
// Register file and write-back stage: two combinational read ports,
// one synchronous write port, and the registered ALU flags.
module regfile_wb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              cout_in,
  input  logic              ovf_in,
  input  logic              ze_in,
  output logic              cout_q,
  output logic              ovf_q,
  output logic              ze_q
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic              fwd_ok;
  logic [FLAG_W-1:0] fd;
  logic [FLAG_W-1:0] fq;

  assign wr_ok  = wr_en && (wr_addr != ZA);
  // Forwarding is suppressed in reset so reads stay 0.
  assign fwd_ok = (BYPASS != 0) && wr_ok && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs_data = '0;
    if (rs_addr != ZA) begin
      if (fwd_ok && (wr_addr == rs_addr))
        rs_data = wr_data;
      else
        rs_data = regs[rs_addr];
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr != ZA) begin
      if (fwd_ok && (wr_addr == rt_addr))
        rt_data = wr_data;
      else
        rt_data = regs[rt_addr];
    end
  end

  always_comb begin
    fd            = '0;
    fd[FLAG_COUT] = cout_in;
    fd[FLAG_OVF]  = ovf_in;
    fd[FLAG_ZE]   = ze_in;
  end

  flag_reg u_flags (
    .clk (clk),
    .rst (rst),
    .en  (flag_we),
    .d   (fd),
    .q   (fq)
  );

  assign cout_q = fq[FLAG_COUT];
  assign ovf_q  = fq[FLAG_OVF];
  assign ze_q   = fq[FLAG_ZE];

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: one instance per BYPASS setting,
// driven from the same stimulus.
module tb_regfile_wb;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic        wr_en, flag_we;
  logic [31:0] wr_data;
  logic        cout_in, ovf_in, ze_in;

  logic [31:0] rs0, rt0, rs1, rt1;
  logic        c0, o0, z0, c1, o1, z1;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs0), .rt_data(rt0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we(flag_we),
    .cout_in(cout_in), .ovf_in(ovf_in), .ze_in(ze_in),
    .cout_q(c0), .ovf_q(o0), .ze_q(z0)
  );

  regfile_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs1), .rt_data(rt1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we(flag_we),
    .cout_in(cout_in), .ovf_in(ovf_in), .ze_in(ze_in),
    .cout_q(c1), .ovf_q(o1), .ze_q(z1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] rs0;
    logic [31:0] rt0;
    logic [31:0] rs1;
    logic [31:0] rt1;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fl0();
    return {29'd0, c0, o0, z0};
  endfunction

  function automatic logic [31:0] fl1();
    return {29'd0, c1, o1, z1};
  endfunction

  initial begin
    tbl[0] = '{1'b1, 5'd3, 32'h139876AD, 5'd3, 5'd3,
               32'h0, 32'h0, 32'h139876AD, 32'h139876AD};
    tbl[1] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd3,
               32'h139876AD, 32'h139876AD,
               32'h139876AD, 32'h139876AD};
    tbl[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd3,
               32'h0, 32'h139876AD, 32'h0, 32'h139876AD};
    tbl[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
               32'h0, 32'h0, 32'h0, 32'h0};
    tbl[4] = '{1'b1, 5'd7, 32'h00000018, 5'd7, 5'd3,
               32'h0, 32'h139876AD, 32'h18, 32'h139876AD};
    tbl[5] = '{1'b1, 5'd7, 32'h00005210, 5'd7, 5'd7,
               32'h18, 32'h18, 32'h5210, 32'h5210};
    tbl[6] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd3,
               32'h5210, 32'h139876AD,
               32'h5210, 32'h139876AD};
    tbl[7] = '{1'b0, 5'd0, 32'h0, 5'd31, 5'd5,
               32'h0, 32'h0, 32'h0, 32'h0};

    rst = 1'b1;
    rs_addr = 5'd0; rt_addr = 5'd0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = '0;
    flag_we = 1'b0;
    cout_in = 1'b0; ovf_in = 1'b0; ze_in = 1'b0;
    #2;
    chk("reset_rs0", rs0, 32'h0);
    chk("reset_flags0", fl0(), 32'h0);
    chk("reset_flags1", fl1(), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      wr_en   = tbl[i].we;
      wr_addr = tbl[i].wa;
      wr_data = tbl[i].wd;
      rs_addr = tbl[i].ra;
      rt_addr = tbl[i].rb;
      #2;
      chk($sformatf("v%0d_rs_b0", i), rs0, tbl[i].rs0);
      chk($sformatf("v%0d_rt_b0", i), rt0, tbl[i].rt0);
      chk($sformatf("v%0d_rs_b1", i), rs1, tbl[i].rs1);
      chk($sformatf("v%0d_rt_b1", i), rt1, tbl[i].rt1);
    end
    @(negedge clk);
    wr_en = 1'b0;

    // r7 after the read-during-write pair
    rs_addr = 5'd7;
    #1;
    chk("rdw_after_b0", rs0, 32'h5210);

    // flags: 0x80000000 + 0x80000000 -> cout, ovf, ze
    @(negedge clk);
    flag_we = 1'b1;
    cout_in = 1'b1; ovf_in = 1'b1; ze_in = 1'b1;
    #1;
    chk("flag_pre_load", fl0(), 32'h0);
    @(posedge clk); #1;
    chk("flag_load_b0", fl0(), 32'h7);
    chk("flag_load_b1", fl1(), 32'h7);
    @(negedge clk);
    flag_we = 1'b0;
    cout_in = 1'b0; ovf_in = 1'b0; ze_in = 1'b0;
    @(posedge clk); #1;
    chk("flag_hold", fl0(), 32'h7);

    // simultaneous write of r31 and flag load
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h2;
    flag_we = 1'b1;
    cout_in = 1'b1; ovf_in = 1'b1; ze_in = 1'b0;
    rs_addr = 5'd31; rt_addr = 5'd31;
    #1;
    chk("sim_pre_r31", rs0, 32'h0);
    chk("sim_pre_ze", {31'd0, z0}, 32'h1);
    @(posedge clk); #1;
    chk("sim_r31", rt0, 32'h2);
    chk("sim_ze", {31'd0, z0}, 32'h0);
    chk("sim_flags", fl0(), 32'h6);
    @(negedge clk);
    wr_en = 1'b0; flag_we = 1'b0;

    // reset mid-operation
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    flag_we = 1'b1;
    cout_in = 1'b1; ovf_in = 1'b0; ze_in = 1'b1;
    rs_addr = 5'd5; rt_addr = 5'd3;
    @(posedge clk); #1;
    chk("rst_pre_r5", rs0, 32'hDEADBEEF);
    chk("rst_pre_flags", fl0(), 32'h5);
    wr_en = 1'b0; flag_we = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_rs_b0", rs0, 32'h0);
    chk("rst_async_rt_b0", rt0, 32'h0);
    chk("rst_async_rs_b1", rs1, 32'h0);
    chk("rst_async_flags", fl0(), 32'h0);

    // rst dominates writes/flag loads at an edge
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h00001234;
    flag_we = 1'b1;
    cout_in = 1'b1; ovf_in = 1'b1; ze_in = 1'b1;
    #1;
    chk("rst_nofwd_b1", rs1, 32'h0);
    @(posedge clk); #1;
    chk("rst_dom_b0", rs0, 32'h0);
    chk("rst_dom_flags", fl0(), 32'h0);

    // first edge after deassertion takes the write
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("deassert_pre_b0", rs0, 32'h0);
    chk("deassert_pre_b1", rs1, 32'h1234);
    @(posedge clk); #1;
    chk("deassert_post_b0", rs0, 32'h1234);
    chk("deassert_post_b1", rs1, 32'h1234);
    chk("deassert_flags", fl1(), 32'h7);
    @(negedge clk);
    wr_en = 1'b0; flag_we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
